// File: rtl/sha256_compress_if.sv
// Handshake bundle for sha256_compress: start/chaining value, W-server read
// port, and the result. The slave modport is the compression core; the
// master modport is the controller or W server side.
interface sha256_compress_if;
  logic         local_go_sig;
  logic [255:0] hash_in;
  logic         w_reg_rdy;
  logic [31:0]  w_reg_data;
  logic         w_reg_read;
  logic [5:0]   w_reg_addr;
  logic [255:0] hash_out;
  logic         done;

  modport slave (
    input  local_go_sig, hash_in, w_reg_rdy, w_reg_data,
    output w_reg_read, w_reg_addr, hash_out, done
  );

  modport master (
    output local_go_sig, hash_in, w_reg_rdy, w_reg_data,
    input  w_reg_read, w_reg_addr, hash_out, done
  );
endinterface

// File: rtl/sha256_compress.sv
// sha256_compress: one SHA-256 compression, one round per W fetch.
// Each round fetches W[t] from an external W server (REQ -> WAIT), then runs
// one FIPS 180-4 round. Optional macro SHA256_COMPRESS_FEEDFORWARD_EN adds
// the chaining value into the result; undefined, the raw a..h are returned.
// The W server must have w_reg_data stable at the pins by the (W_LAT-2)th
// cycle after the cycle the read pulse is visible, because the data passes
// through the input register before capture on the last WAIT cycle.
module sha256_compress #(
  parameter int W_LAT = 3
) (
  input  logic             clock,
  input  logic             reset,
  sha256_compress_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_REQ, S_WAIT, S_ROUND, S_DONE} state_t;

  localparam logic [2:0] WCNT_LAST = 3'(W_LAT - 1);

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t       r_state, w_nxt;
  logic         r_go, r_rdy;
  logic [31:0]  r_wdata, r_wcur;
  logic [5:0]   r_t, r_addr;
  logic [2:0]   r_wcnt;
  logic         r_read, r_done;
  logic [255:0] r_hash;
  logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;

  logic         w_init, w_issue, w_cap, w_round, w_fin;
  logic [31:0]  w_s0, w_s1, w_ch, w_maj, w_t1, w_t2, w_na, w_ne;

  // Register the control/data inputs once; all decisions use these copies.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_go    <= 1'b0;
      r_rdy   <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_go    <= bus.local_go_sig;
      r_rdy   <= bus.w_reg_rdy;
      r_wdata <= bus.w_reg_data;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_go) w_nxt = S_INIT;
      S_INIT:  w_nxt = S_REQ;
      S_REQ:   if (r_rdy) w_nxt = S_WAIT;
      S_WAIT:  if (r_wcnt == WCNT_LAST) w_nxt = S_ROUND;
      S_ROUND: w_nxt = (r_t == 6'd63) ? S_DONE : S_REQ;
      S_DONE:  if (!r_go) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State-decoded strobes driving the datapath.
  always_comb begin
    w_init  = 1'b0;
    w_issue = 1'b0;
    w_cap   = 1'b0;
    w_round = 1'b0;
    w_fin   = 1'b0;
    case (r_state)
      S_INIT:  w_init = 1'b1;
      S_REQ:   w_issue = r_rdy;
      S_WAIT:  w_cap = (r_wcnt == WCNT_LAST);
      S_ROUND: begin
        w_round = 1'b1;
        w_fin   = (r_t == 6'd63);
      end
      default: ;
    endcase
  end

  // Round function on the current working variables.
  always_comb begin
    w_s1  = {r_e[5:0], r_e[31:6]} ^ {r_e[10:0], r_e[31:11]} ^ {r_e[24:0], r_e[31:25]};
    w_s0  = {r_a[1:0], r_a[31:2]} ^ {r_a[12:0], r_a[31:13]} ^ {r_a[21:0], r_a[31:22]};
    w_ch  = (r_e & r_f) ^ (~r_e & r_g);
    w_maj = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
    w_t1  = r_h + w_s1 + w_ch + K[r_t] + r_wcur;
    w_t2  = w_s0 + w_maj;
    w_na  = w_t1 + w_t2;
    w_ne  = r_d + w_t1;
  end

  // Datapath: working variables, round index, W fetch, result and done.
  always_ff @(posedge clock) begin
    if (!reset) begin
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
      r_t    <= '0;
      r_wcnt <= '0;
      r_wcur <= '0;
      r_read <= 1'b0;
      r_addr <= '0;
      r_hash <= '0;
      r_done <= 1'b0;
    end else begin
      r_read <= w_issue;
      if (w_issue) r_addr <= r_t;
      r_wcnt <= (r_state == S_WAIT) ? r_wcnt + 3'd1 : 3'd0;
      if (w_cap) r_wcur <= r_wdata;
      if (w_init) begin
        {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= bus.hash_in;
        r_t <= '0;
      end else if (w_round) begin
        {r_a, r_b, r_c, r_d} <= {w_na, r_a, r_b, r_c};
        {r_e, r_f, r_g, r_h} <= {w_ne, r_e, r_f, r_g};
        r_t <= r_t + 6'd1;
      end
      if (w_fin) begin
`ifdef SHA256_COMPRESS_FEEDFORWARD_EN
        r_hash <= {w_na + bus.hash_in[255:224], r_a  + bus.hash_in[223:192],
                   r_b  + bus.hash_in[191:160], r_c  + bus.hash_in[159:128],
                   w_ne + bus.hash_in[127:96],  r_e  + bus.hash_in[95:64],
                   r_f  + bus.hash_in[63:32],   r_g  + bus.hash_in[31:0]};
`else
        r_hash <= {w_na, r_a, r_b, r_c, w_ne, r_e, r_f, r_g};
`endif
      end
      r_done <= (w_nxt == S_DONE);
    end
  end

  assign bus.w_reg_read = r_read;
  assign bus.w_reg_addr = r_addr;
  assign bus.hash_out   = r_hash;
  assign bus.done       = r_done;

endmodule
